// File: rtl/connect4_move_ctrl.sv
// ---------------------------------------------------------------------------
// connect4_move_ctrl
//
// Move controller for a 4-column Connect-4 board. It turns synchronized
// button levels into validated moves:
//   - left/right presses move a column cursor,
//   - a drop press latches the cursor column, checks its height, and for a
//     legal move emits a one-cycle add strobe plus a board cell write,
//   - it tracks the side to move and the number of committed moves.
//
// Configuration macro:
//   CONNECT4_CURSOR_WRAP_EN  defined   -> cursor wraps 3 <-> 0
//                            undefined -> cursor saturates at 0 and 3
//
// Move timing, where the drop press is sampled at edge N:
//   N   : IDLE   -> CHECK   (sel_col latched)
//   N+1 : CHECK  -> COMMIT  (add/wr_en high for one full cycle)
//         or CHECK -> IDLE with reject high for one cycle
//   N+2 : COMMIT -> SETTLE  (player toggles, move_count increments)
//   N+3 : SETTLE -> IDLE
// ---------------------------------------------------------------------------
module connect4_move_ctrl #(
    parameter int ROWS = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_drop,
    input  logic       game_over,
    input  logic [2:0] height_0,
    input  logic [2:0] height_1,
    input  logic [2:0] height_2,
    input  logic [2:0] height_3,
    output logic [1:0] cursor,
    output logic [1:0] sel_col,
    output logic       add,
    output logic       wr_en,
    output logic [2:0] wr_row,
    output logic [1:0] wr_col,
    output logic       wr_player,
    output logic       player,
    output logic       reject,
    output logic [4:0] move_count,
    output logic       board_full
);

    // Column height at which a column is full, and total cells on the board.
    localparam logic [2:0] FULL_HEIGHT = 3'(ROWS);
    localparam logic [4:0] MAX_MOVES   = 5'(4 * ROWS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        COMMIT = 2'd2,
        SETTLE = 2'd3
    } state_t;

    state_t state;

    // Previous button levels for rising-edge detection.
    logic prev_left;
    logic prev_right;
    logic prev_drop;

    logic press_left;
    logic press_right;
    logic press_drop;

    logic       blocked;
    logic [2:0] sel_height;
    logic [1:0] cursor_next;

    assign press_left  = btn_left  & ~prev_left;
    assign press_right = btn_right & ~prev_right;
    assign press_drop  = btn_drop  & ~prev_drop;

    // A won game or a full board freezes every input.
    assign blocked = game_over | board_full;

    // Track previous button levels; reset to 1 so a button held through reset needs a fresh press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_left  <= 1'b1;
            prev_right <= 1'b1;
            prev_drop  <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of block order.
            prev_left  <= btn_left;
            prev_right <= btn_right;
            prev_drop  <= btn_drop;
        end
    end

    // Select the height of the latched column.
    always_comb begin
        // NOTE: assign a default before the case so no path leaves the
        // variable unassigned, which would otherwise infer a latch.
        sel_height = height_0;
        case (sel_col)
            2'd1:    sel_height = height_1;
            2'd2:    sel_height = height_2;
            2'd3:    sel_height = height_3;
            default: sel_height = height_0;
        endcase
    end

    // Next cursor position from left/right presses; simultaneous presses cancel.
    always_comb begin
        cursor_next = cursor;
        if (press_left && !press_right) begin
`ifdef CONNECT4_CURSOR_WRAP_EN
            cursor_next = cursor - 2'd1;
`else
            if (cursor != 2'd0) begin
                cursor_next = cursor - 2'd1;
            end
`endif
        end else if (press_right && !press_left) begin
`ifdef CONNECT4_CURSOR_WRAP_EN
            cursor_next = cursor + 2'd1;
`else
            if (cursor != 2'd3) begin
                cursor_next = cursor + 2'd1;
            end
`endif
        end
    end

    // Move FSM with registered strobes, board write command, turn and move counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cursor     <= 2'd0;
            sel_col    <= 2'd0;
            add        <= 1'b0;
            wr_en      <= 1'b0;
            wr_row     <= 3'd0;
            wr_col     <= 2'd0;
            wr_player  <= 1'b0;
            player     <= 1'b0;
            reject     <= 1'b0;
            move_count <= 5'd0;
            board_full <= 1'b0;
        end else begin
            // Strobes are high for exactly the cycle after the edge that sets them.
            add    <= 1'b0;
            wr_en  <= 1'b0;
            reject <= 1'b0;

            case (state)
                IDLE: begin
                    if (!blocked) begin
                        if (press_drop) begin
                            // A drop takes priority; cursor presses in this cycle are dropped.
                            sel_col <= cursor;
                            state   <= CHECK;
                        end else begin
                            cursor <= cursor_next;
                        end
                    end
                end

                CHECK: begin
                    if (sel_height >= FULL_HEIGHT) begin
                        reject <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        // The write targets the pre-increment height, i.e. the lowest free row.
                        add       <= 1'b1;
                        wr_en     <= 1'b1;
                        wr_row    <= sel_height;
                        wr_col    <= sel_col;
                        wr_player <= player;
                        state     <= COMMIT;
                    end
                end

                COMMIT: begin
                    player <= ~player;
                    if (move_count != MAX_MOVES) begin
                        move_count <= move_count + 5'd1;
                        board_full <= ((move_count + 5'd1) == MAX_MOVES);
                    end
                    state <= SETTLE;
                end

                SETTLE: begin
                    // Gives the counter stage a clean cycle before the next drop is accepted.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_connect4_move_ctrl.sv
// ---------------------------------------------------------------------------
// tb_connect4_move_ctrl
//
// Self-checking bench for connect4_move_ctrl (ROWS = 6). Emulates the
// negedge-clocked column-height counter stage, runs directed sequences and a
// vector table, then random button actions against an action-level model.
// Honors CONNECT4_CURSOR_WRAP_EN for the expected cursor behaviour.
// ---------------------------------------------------------------------------
module tb_connect4_move_ctrl;

    localparam int ROWS = 6;
    localparam int MAXM = 4 * ROWS;

`ifdef CONNECT4_CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_left, btn_right, btn_drop, game_over;
    logic [2:0] height_0, height_1, height_2, height_3;
    logic [1:0] cursor, sel_col, wr_col;
    logic       add, wr_en, wr_player, player, reject, board_full;
    logic [2:0] wr_row;
    logic [4:0] move_count;

    connect4_move_ctrl #(.ROWS(ROWS)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_drop   (btn_drop),
        .game_over  (game_over),
        .height_0   (height_0),
        .height_1   (height_1),
        .height_2   (height_2),
        .height_3   (height_3),
        .cursor     (cursor),
        .sel_col    (sel_col),
        .add        (add),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_player  (wr_player),
        .player     (player),
        .reject     (reject),
        .move_count (move_count),
        .board_full (board_full)
    );

    always #5 clk = ~clk;

    // ---------------- counter-stage emulation and monitor ----------------
    logic [2:0] h [4];
    logic       h_clr   = 1'b1;
    logic       h_full1 = 1'b0;
    int tot_add = 0, tot_rej = 0, tot_wrbad = 0;
    int last_row = 0, last_col = 0, last_ply = 0;

    assign height_0 = h[0];
    assign height_1 = h[1];
    assign height_2 = h[2];
    assign height_3 = h[3];

    always @(negedge clk) begin
        if (h_clr) begin
            for (int i = 0; i < 4; i++) h[i] = 3'd0;
        end else if (h_full1) begin
            h[1] = 3'(ROWS);
        end else if (add) begin
            h[sel_col] = h[sel_col] + 3'd1;
        end
        if (add) begin
            tot_add++;
            last_row = int'(wr_row);
            last_col = int'(wr_col);
            last_ply = int'(wr_player);
        end
        if (reject) tot_rej++;
        if (wr_en !== add) tot_wrbad++;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // ---------------- action-level reference model ----------------
    int m_cur, m_ply, m_cnt;
    int m_h [4];

    task automatic model_clear();
        m_cur = 0; m_ply = 0; m_cnt = 0;
        for (int i = 0; i < 4; i++) m_h[i] = 0;
    endtask

    // a: 0 left, 1 right, 2 drop, 3 left+right
    task automatic model_step(input int a, input bit go, output int adds, output int rejs);
        adds = 0;
        rejs = 0;
        if (!go && m_cnt < MAXM) begin
            case (a)
                0: m_cur = WRAP ? (m_cur + 3) % 4 : (m_cur > 0 ? m_cur - 1 : 0);
                1: m_cur = WRAP ? (m_cur + 1) % 4 : (m_cur < 3 ? m_cur + 1 : 3);
                2: begin
                    if (m_h[m_cur] >= ROWS) begin
                        rejs = 1;
                    end else begin
                        m_h[m_cur]++;
                        m_ply = 1 - m_ply;
                        m_cnt++;
                        adds = 1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        reset = 1'b1;
        h_clr = 1'b1;
        btn_left = 1'b0;
        btn_right = 1'b0;
        game_over = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        h_clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic set_col1_full();
        h_full1 = 1'b1;
        @(negedge clk);
        #1;
        h_full1 = 1'b0;
        m_h[1] = ROWS;
    endtask

    // One press (one-cycle button pulse) followed by enough cycles to settle.
    task automatic act(input int a, input bit go);
        game_over = go;
        @(posedge clk);
        #1;
        btn_left  = (a == 0 || a == 3);
        btn_right = (a == 1 || a == 3);
        btn_drop  = (a == 2);
        @(posedge clk);
        #1;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_drop  = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        game_over = 1'b0;
    endtask

    task automatic act_check(input int a, input bit go, input string tag);
        int a0, r0, w0, pre_cur, pre_ply, pre_h, e_add, e_rej;
        a0 = tot_add; r0 = tot_rej; w0 = tot_wrbad;
        pre_cur = m_cur; pre_ply = m_ply; pre_h = m_h[m_cur];
        model_step(a, go, e_add, e_rej);
        act(a, go);
        check({tag, " cursor"},     int'(cursor),     m_cur);
        check({tag, " player"},     int'(player),     m_ply);
        check({tag, " move_count"}, int'(move_count), m_cnt);
        check({tag, " board_full"}, int'(board_full), int'(m_cnt == MAXM));
        check({tag, " add pulses"}, tot_add - a0,     e_add);
        check({tag, " reject"},     tot_rej - r0,     e_rej);
        check({tag, " wr_en/add"},  tot_wrbad - w0,   0);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s height_%0d", tag, i), int'(h[i]), m_h[i]);
        if (e_add == 1) begin
            check({tag, " wr_row"},    last_row, pre_h);
            check({tag, " wr_col"},    last_col, pre_cur);
            check({tag, " wr_player"}, last_ply, pre_ply);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int act;
        int go;
        int cur;
        int ply;
        int cnt;
        int adds;
        int rejs;
    } vec_t;

    localparam int G_CUR = WRAP ? 3 : 0;   // left from column 0
    localparam int H_CUR = WRAP ? 0 : 1;   // then right

    vec_t vecs [9];

    initial begin
        int a0, r0, a, go;

        vecs[0] = '{3, 0, 2,     1, 1, 0, 0};
        vecs[1] = '{2, 0, 2,     0, 2, 1, 0};
        vecs[2] = '{0, 0, 1,     0, 2, 0, 0};
        vecs[3] = '{2, 1, 1,     0, 2, 0, 0};
        vecs[4] = '{0, 1, 1,     0, 2, 0, 0};
        vecs[5] = '{0, 0, 0,     0, 2, 0, 0};
        vecs[6] = '{0, 0, G_CUR, 0, 2, 0, 0};
        vecs[7] = '{1, 0, H_CUR, 0, 2, 0, 0};
        vecs[8] = '{2, 0, H_CUR, 1, 3, 1, 0};

        btn_drop = 1'b0;
        do_reset();

        // Reset defaults
        check("rst cursor",     int'(cursor),     0);
        check("rst sel_col",    int'(sel_col),    0);
        check("rst player",     int'(player),     0);
        check("rst move_count", int'(move_count), 0);
        check("rst board_full", int'(board_full), 0);
        check("rst add",        int'(add),        0);
        check("rst wr_en",      int'(wr_en),      0);
        check("rst reject",     int'(reject),     0);

        // Legal drop on column 2 with cycle-level timing
        act(1, 1'b0);
        act(1, 1'b0);
        check("ld cursor", int'(cursor), 2);
        @(posedge clk); #1; btn_drop = 1'b1;
        @(posedge clk); #1; btn_drop = 1'b0;          // edge N passed: CHECK
        check("ld N add",      int'(add),   0);
        check("ld N sel_col",  int'(sel_col), 2);
        @(posedge clk); #1;                           // COMMIT
        check("ld N1 add",       int'(add),       1);
        check("ld N1 wr_en",     int'(wr_en),     1);
        check("ld N1 wr_row",    int'(wr_row),    0);
        check("ld N1 wr_col",    int'(wr_col),    2);
        check("ld N1 wr_player", int'(wr_player), 0);
        check("ld N1 player",    int'(player),    0);
        @(posedge clk); #1;                           // SETTLE
        check("ld N2 add",        int'(add),        0);
        check("ld N2 player",     int'(player),     1);
        check("ld N2 move_count", int'(move_count), 1);
        check("ld N2 height_2",   int'(h[2]),       1);
        repeat (2) @(posedge clk); #1;

        // Table-driven vectors continuing from cursor 2, player 1, one move
        foreach (vecs[i]) begin
            a0 = tot_add; r0 = tot_rej;
            act(vecs[i].act, vecs[i].go[0]);
            check($sformatf("vec%0d cursor", i),     int'(cursor),     vecs[i].cur);
            check($sformatf("vec%0d player", i),     int'(player),     vecs[i].ply);
            check($sformatf("vec%0d move_count", i), int'(move_count), vecs[i].cnt);
            check($sformatf("vec%0d add", i),        tot_add - a0,     vecs[i].adds);
            check($sformatf("vec%0d reject", i),     tot_rej - r0,     vecs[i].rejs);
        end

        // Reset in the middle of COMMIT
        do_reset();
        act(1, 1'b0);
        @(posedge clk); #1; btn_drop = 1'b1;
        @(posedge clk); #1; btn_drop = 1'b0;
        @(posedge clk); #1;
        check("mid add before reset", int'(add), 1);
        reset = 1'b1;
        #1;
        check("mid add",        int'(add),        0);
        check("mid wr_en",      int'(wr_en),      0);
        check("mid player",     int'(player),     0);
        check("mid move_count", int'(move_count), 0);
        check("mid cursor",     int'(cursor),     0);
        check("mid sel_col",    int'(sel_col),    0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("mid after add count", int'(move_count), 0);

        // Cursor edge behaviour
        do_reset();
        for (int i = 0; i < 4; i++) act_check(1, 1'b0, "edge right");
        check("edge cursor after 4 rights", int'(cursor), WRAP ? 0 : 3);
        act_check(3, 1'b0, "edge both");

        // Full column rejects
        do_reset();
        set_col1_full();
        act_check(1, 1'b0, "full right");
        act_check(2, 1'b0, "full drop");
        check("full reject pulses total", tot_rej > 0 ? 1 : 0, 1);

        // Button held through reset release
        btn_drop = 1'b1;
        do_reset();
        a0 = tot_add;
        repeat (5) @(posedge clk); #1;
        check("held add", tot_add - a0, 0);
        check("held move_count", int'(move_count), 0);
        btn_drop = 1'b0;
        repeat (2) @(posedge clk); #1;
        act_check(2, 1'b0, "held then press");

        // Fill the whole board, then confirm everything is blocked
        do_reset();
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < ROWS; r++) act_check(2, 1'b0, "fill drop");
            if (c < 3) act_check(1, 1'b0, "fill right");
        end
        check("fill move_count", int'(move_count), MAXM);
        check("fill board_full", int'(board_full), 1);
        act_check(2, 1'b0, "full board drop");
        act_check(0, 1'b0, "full board left");

        // Random actions against the model
        for (int i = 0; i < 160; i++) begin
            if (i % 40 == 0) do_reset();
            a  = int'($urandom_range(0, 5));
            if (a > 3) a = 2;
            go = ($urandom_range(0, 7) == 0) ? 1 : 0;
            act_check(a, go[0], $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
